// File: rtl/fir_tdm.sv
// fir_tdm: time-multiplexed multi-channel FIR filter.
//
// One shared multiply-accumulate engine serves N_CH channels. Each channel
// has its own circular delay line of N_TAPS samples and its own write
// pointer. A sample takes N_TAPS+2 cycles: accept, N_TAPS MAC cycles and one
// output cycle. Coefficients are written serially into a shadow bank and
// copied into the active bank only while the engine is idle, so a running
// convolution never sees a mix of old and new coefficients.
//
// Optional build macro:
//   FIR_TDM_SAT_EN  defined   -> output saturates to the OUT_WIDTH range
//                   undefined -> output keeps the low OUT_WIDTH bits (wrap)
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset (clears everything)
//   clr         synchronous datapath clear (coefficients are kept)
//   coeff_wr    write coeff_data into shadow[coeff_addr]
//   coeff_addr  tap index (values >= N_TAPS are ignored)
//   coeff_data  signed coefficient
//   coeff_swap  request copy of shadow bank into active bank
//   in_valid    sample offered
//   in_ready    engine idle, sample can be accepted
//   in_ch       channel of offered sample (>= N_CH is discarded)
//   in_data     signed sample
//   out_valid   one-cycle result strobe
//   out_ch      channel of result
//   out_data    signed filtered result
module fir_tdm #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int COEFF_WIDTH  = 16,
  parameter int N_TAPS       = 41,
  parameter int N_CH         = 4,
  parameter int OUT_WIDTH    = 16,
  parameter int SHIFT        = 15,
  localparam int ACC_W = SAMPLE_WIDTH + COEFF_WIDTH + $clog2(N_TAPS),
  localparam int AW    = (N_TAPS > 1) ? $clog2(N_TAPS) : 1,
  localparam int CW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  input  logic                          coeff_wr,
  input  logic [AW-1:0]                 coeff_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_data,
  input  logic                          coeff_swap,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CW-1:0]                 in_ch,
  input  logic signed [SAMPLE_WIDTH-1:0] in_data,
  output logic                          out_valid,
  output logic [CW-1:0]                 out_ch,
  output logic signed [OUT_WIDTH-1:0]   out_data
);

  // One guard bit above the accumulator so the rounding add cannot overflow.
  localparam int RW  = ACC_W + 1;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [RW-1:0] ROUND = (SHIFT > 0) ? (RW'(1) <<< RSH) : RW'(0);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_e;

  state_e                         state_q, state_d;
  logic signed [SAMPLE_WIDTH-1:0] x_q      [N_CH][N_TAPS];
  logic        [AW-1:0]           wr_ptr_q [N_CH];
  logic signed [COEFF_WIDTH-1:0]  shadow_q [N_TAPS];
  logic signed [COEFF_WIDTH-1:0]  active_q [N_TAPS];
  logic        [AW-1:0]           k_q;
  logic        [CW-1:0]           ch_q;
  logic signed [ACC_W-1:0]        acc_q;
  logic                           swap_pending_q;
  logic                           out_valid_q;
  logic        [CW-1:0]           out_ch_q;
  logic signed [OUT_WIDTH-1:0]    out_data_q;

  logic                           ch_ok;
  logic                           accept;
  logic                           mac_last;
  logic                           swap_now;
  logic        [AW:0]             rd_sum;
  logic        [AW-1:0]           rd_idx;
  logic signed [ACC_W-1:0]        prod;
  logic signed [RW-1:0]           acc_rnd;
  logic signed [RW-1:0]           r;
  logic signed [OUT_WIDTH-1:0]    fit;

  assign ch_ok    = ({1'b0, in_ch} < (CW+1)'(N_CH));
  assign in_ready = (state_q == S_IDLE);
  assign accept   = in_ready && in_valid && ch_ok && !clr;
  assign mac_last = (k_q == AW'(N_TAPS - 1));
  // The pending flag and a same-edge request both take effect at an idle edge,
  // so a sample accepted on that edge already runs with the new bank.
  assign swap_now = (swap_pending_q || coeff_swap) && (state_q == S_IDLE);

  // Circular read of x[ch][(wr_ptr - k) mod N_TAPS]; newest sample is tap 0.
  assign rd_sum = (wr_ptr_q[ch_q] >= k_q)
                ? {1'b0, wr_ptr_q[ch_q]} - {1'b0, k_q}
                : {1'b0, wr_ptr_q[ch_q]} + (AW+1)'(N_TAPS) - {1'b0, k_q};
  assign rd_idx = AW'(rd_sum);
  assign prod   = ACC_W'(active_q[k_q]) * ACC_W'(x_q[ch_q][rd_idx]);

  // Round half up, then arithmetic shift.
  assign acc_rnd = RW'(acc_q) + ROUND;
  assign r       = acc_rnd >>> SHIFT;

`ifdef FIR_TDM_SAT_EN
  localparam logic signed [RW-1:0] OUT_MAX = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] OUT_MIN = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
  always_comb begin
    if (r > OUT_MAX)      fit = OUT_WIDTH'(OUT_MAX);
    else if (r < OUT_MIN) fit = OUT_WIDTH'(OUT_MIN);
    else                  fit = OUT_WIDTH'(r);
  end
`else
  assign fit = OUT_WIDTH'(r);
`endif

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid && ch_ok) state_d = S_MAC;
      S_MAC:   if (mac_last) state_d = S_OUT;
      S_OUT:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (clr) state_d = S_IDLE;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the delay lines and coefficient banks are reset explicitly,
      // because the filter must produce deterministic output right after reset.
      for (int c = 0; c < N_CH; c++) begin
        wr_ptr_q[c] <= '0;
        for (int t = 0; t < N_TAPS; t++) x_q[c][t] <= '0;
      end
      for (int t = 0; t < N_TAPS; t++) begin
        shadow_q[t] <= '0;
        active_q[t] <= '0;
      end
      state_q        <= S_IDLE;
      k_q            <= '0;
      ch_q           <= '0;
      acc_q          <= '0;
      swap_pending_q <= 1'b0;
      out_valid_q    <= 1'b0;
      out_ch_q       <= '0;
      out_data_q     <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;

      // Coefficient bank control runs independently of clr.
      if (coeff_wr && ({1'b0, coeff_addr} < (AW+1)'(N_TAPS)))
        shadow_q[coeff_addr] <= coeff_data;
      if (swap_now) begin
        active_q       <= shadow_q;
        swap_pending_q <= 1'b0;
      end else if (coeff_swap) begin
        swap_pending_q <= 1'b1;
      end

      if (clr) begin
        for (int c = 0; c < N_CH; c++) begin
          wr_ptr_q[c] <= '0;
          for (int t = 0; t < N_TAPS; t++) x_q[c][t] <= '0;
        end
        acc_q <= '0;
        k_q   <= '0;
      end else begin
        if (accept) begin
          x_q[in_ch][wr_ptr_q[in_ch]] <= in_data;
          ch_q  <= in_ch;
          k_q   <= '0;
          acc_q <= '0;
        end
        if (state_q == S_MAC) begin
          acc_q <= acc_q + prod;
          k_q   <= k_q + AW'(1);
          if (mac_last)
            wr_ptr_q[ch_q] <= (wr_ptr_q[ch_q] == AW'(N_TAPS - 1)) ? '0 : wr_ptr_q[ch_q] + AW'(1);
        end
        if (state_q == S_OUT) begin
          out_valid_q <= 1'b1;
          out_ch_q    <= ch_q;
          out_data_q  <= fit;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule
